// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM: state enum,
// opcodes, datapath select codes and ALU control codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_ctrl_t;

   // What the FSM asks of the ALU; ALUOP_FUNCT defers to funct3/funct7b5.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;

   localparam logic [1:0] SRC_B_RS2    = 2'b00;
   localparam logic [1:0] SRC_B_IMM    = 2'b01;
   localparam logic [1:0] SRC_B_FOUR   = 2'b10;

   localparam logic [1:0] RES_ALU_OUT  = 2'b00;
   localparam logic [1:0] RES_DATA     = 2'b01;
   localparam logic [1:0] RES_ALU_RES  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src_for(input logic [6:0] op);
      logic [1:0] imm;
      imm = IMM_I;
      case (op)
         OP_SW:     imm = IMM_S;
         OP_BRANCH: imm = IMM_B;
         OP_JAL:    imm = IMM_J;
         default:   imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: fixed add/sub requests from the FSM, or
// the funct3/funct7b5 mapping for R- and I-type execute states.
module alu_op_decode
   import mc_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only R-type (op5=1) with funct7b5 selects sub; addi ignores it.
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_control = ALU_SLL;
               3'b010:  alu_control = ALU_SLT;
               3'b011:  alu_control = ALU_ADD;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_fsm.sv
// Moore control FSM for a multicycle RISC-V style datapath.
// Define MEM_WAIT_EN to add mem_ready and stall FETCH/MEMREAD/MEMWRITE on it.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4
// DECODE     | read registers, precompute branch/jump target
// MEMADR     | compute load/store address
// MEMREAD    | read data memory
// MEMWB      | write loaded data to register file
// MEMWRITE   | write data memory
// EXECR      | R-type ALU operation
// ALUWB      | write ALU result to register file
// EXECI      | I-type ALU operation
// JAL        | PC <= target, link address computed
// BRANCH     | compare, conditionally load PC
module multicycle_fsm
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
`ifdef MEM_WAIT_EN
   input  logic       mem_ready,
`endif
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [2:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   state_t  state_q;
   state_t  state_d;
   alu_op_t alu_op;
   logic    ready;
   logic    pc_update;
   logic    branch;
   logic    mem_write_c;
   logic    ir_write_c;
   logic    reg_write_c;
   logic    illegal_c;

`ifdef MEM_WAIT_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_update   = 1'b0;
      branch      = 1'b0;
      adr_src     = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      illegal_c   = 1'b0;
      result_src  = RES_ALU_OUT;
      alu_src_a   = SRC_A_PC;
      alu_src_b   = SRC_B_RS2;
      alu_op      = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU_RES;
            if (ready) begin
               ir_write_c = 1'b1;
               pc_update  = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECR;
               OP_ITYPE:     state_d = S_EXECI;
               OP_JAL:       state_d = S_JAL;
               OP_BRANCH:    state_d = S_BRANCH;
               default: begin
                  illegal_c = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALU_OUT;
            if (ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            result_src  = RES_DATA;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            // Address and strobe stay asserted for the whole wait.
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            if (ready) begin
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src  = RES_ALU_OUT;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRC_A_OLD_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU_OUT;
            pc_update  = 1'b1;
            state_d    = S_ALUWB;
         end
         S_BRANCH: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALU_OUT;
            branch     = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   alu_op_decode u_alu_op_decode (
      .alu_op      (alu_op),
      .op5         (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

   // funct3[0] flips the zero test: beq takes on zero, bne on non-zero.
   assign pc_write  = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
   assign ir_write  = ~reset & ir_write_c;
   assign reg_write = ~reset & reg_write_c;
   assign mem_write = ~reset & mem_write_c;
   assign illegal   = ~reset & illegal_c;
   assign imm_src   = imm_src_for(op);
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scoreboard bench for multicycle_fsm: instructions are expanded into expected
// per-cycle outputs from the instruction-class rules; a monitor checks each cycle.
module tb_multicycle_fsm;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BR  = 7'b1100011;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] res;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] imm;
      logic [2:0] alu;
      logic       ill;
   } obs_t;

   typedef struct {
      obs_t  o;
      string tag;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   exp_t exp_q[$];
   int   total;
   int   bad;

   multicycle_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
`ifdef MEM_WAIT_EN
      .mem_ready   (mem_ready),
`endif
      .pc_write    (pc_write),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .illegal     (illegal),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic bit supported(input logic [6:0] o);
      return (o == T_LW) || (o == T_SW) || (o == T_R) || (o == T_I) ||
             (o == T_JAL) || (o == T_BR);
   endfunction

   function automatic logic [1:0] exp_imm(input logic [6:0] o);
      if (o == T_SW)  return 2'b01;
      if (o == T_BR)  return 2'b10;
      if (o == T_JAL) return 2'b11;
      return 2'b00;
   endfunction

   // ALU code for an arithmetic instruction: add/sub/and/or/xor/slt/sll/srl = 0..7
   function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
      case (f3)
         3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
         3'd1:    return 3'd6;
         3'd2:    return 3'd5;
         3'd4:    return 3'd4;
         3'd5:    return 3'd7;
         3'd6:    return 3'd3;
         3'd7:    return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic obs_t exp_out(input int s, input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7, input logic z, input logic r);
      obs_t e;
      e     = '0;
      e.st  = 4'(s);
      e.imm = exp_imm(o);
      case (s)
         0:  begin e.b = 2'b10; e.res = 2'b10; e.irw = r; e.pcw = r; end
         1:  begin e.a = 2'b01; e.b = 2'b01; e.ill = !supported(o); end
         2:  begin e.a = 2'b10; e.b = 2'b01; end
         3:  e.adr = 1'b1;
         4:  begin e.res = 2'b01; e.regw = 1'b1; end
         5:  begin e.adr = 1'b1; e.memw = 1'b1; end
         6:  begin e.a = 2'b10; e.alu = exp_alu(o, f3, f7); end
         7:  e.regw = 1'b1;
         8:  begin e.a = 2'b10; e.b = 2'b01; e.alu = exp_alu(o, f3, f7); end
         9:  begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
         10: begin e.a = 2'b10; e.alu = 3'd1; e.pcw = f3[0] ? !z : z; end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the last cycle.
   task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input int fw, input int mw, input string tag);
      int   sts[$];
      logic rq[$];
      exp_t e;
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      for (int i = 0; i <= fw; i++) begin sts.push_back(0); rq.push_back(i == fw); end
      sts.push_back(1); rq.push_back(1'($urandom_range(0, 1)));
      if (o == T_LW || o == T_SW) begin
         sts.push_back(2); rq.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i <= mw; i++) begin
            sts.push_back(o == T_LW ? 3 : 5); rq.push_back(i == mw);
         end
         if (o == T_LW) begin sts.push_back(4); rq.push_back(1'($urandom_range(0, 1))); end
      end else if (o == T_R || o == T_I || o == T_JAL) begin
         sts.push_back(o == T_R ? 6 : (o == T_I ? 8 : 9)); rq.push_back(1'($urandom_range(0, 1)));
         sts.push_back(7); rq.push_back(1'($urandom_range(0, 1)));
      end else if (o == T_BR) begin
         sts.push_back(10); rq.push_back(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < sts.size(); i++) begin
         e.o   = exp_out(sts[i], o, f3, f7, z, rq[i]);
         e.tag = $sformatf("%s[%0d]", tag, i);
         exp_q.push_back(e);
      end
      for (int i = 0; i < sts.size(); i++) begin
         mem_ready = rq[i];
         @(posedge clk);
         #1;
      end
      chk({tag, "_end_state"}, 32'(state), 32'd0);
   endtask

   initial begin
      int   fw, mw, k;
      logic [6:0] o;
      total = 0; bad = 0;
      reset = 1'b1; op = 7'h7F; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

      fork
         begin : monitor
            exp_t e;
            obs_t a;
            forever begin
               @(negedge clk);
               if (!reset && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  a = '{state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                        alu_src_a, alu_src_b, imm_src, alu_control, illegal};
                  total++;
                  if (a !== e.o) begin
                     bad++;
                     $display("FAIL %s: actual=%h required=%h (state %0d vs %0d)",
                              e.tag, a, e.o, a.st, e.o.st);
                  end
               end
            end
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_wen", 32'({pc_write, ir_write, reg_write, mem_write, illegal}), 32'd0);
      reset = 1'b0;

      // Reset mid-EXECR must abandon the R-type before its writeback.
      op = T_R; funct3 = 3'd0; funct7b5 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_execr", 32'(state), 32'd6);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_wen", 32'({pc_write, ir_write, reg_write, mem_write, illegal}), 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_regw", 32'(reg_write), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_state", 32'(state), 32'd0);
      chk("post_rst_irw_pcw", 32'({ir_write, pc_write}), 32'h3);

      issue(T_LW, 3'd2, 1'b0, 1'b0, 0, 0, "lw");
      issue(T_R,  3'd0, 1'b1, 1'b0, 0, 0, "sub");
      issue(T_R,  3'd0, 1'b0, 1'b0, 0, 0, "add");
      issue(T_I,  3'd0, 1'b1, 1'b0, 0, 0, "addi_f7");
      issue(T_BR, 3'd0, 1'b0, 1'b1, 0, 0, "beq_z1");
      issue(T_BR, 3'd1, 1'b0, 1'b1, 0, 0, "bne_z1");
      issue(T_BR, 3'd1, 1'b0, 1'b0, 0, 0, "bne_z0");
      issue(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, "illegal");
      issue(T_JAL, 3'd0, 1'b0, 1'b0, 0, 0, "jal");
      issue(T_SW, 3'd2, 1'b0, 1'b0, 0, 0, "sw");
`ifdef MEM_WAIT_EN
      issue(T_SW, 3'd2, 1'b0, 1'b0, 0, 3, "sw_wait3");
      issue(T_LW, 3'd2, 1'b0, 1'b0, 2, 1, "lw_wait");
`endif

      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: o = T_LW;
            1: o = T_SW;
            2: o = T_R;
            3: o = T_I;
            4: o = T_JAL;
            5, 6: o = T_BR;
            default: begin
               o = 7'($urandom);
               while (supported(o)) o = 7'($urandom);
            end
         endcase
         fw = 0; mw = 0;
`ifdef MEM_WAIT_EN
         fw = $urandom_range(0, 2);
         mw = $urandom_range(0, 2);
`endif
         issue(o, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw, $sformatf("rnd%0d", n));
      end

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have inputs op [6:0], funct3 [2:0], funct7b5 (1), and zero (1, ALU result == 0).
REQ-004 SHALL have input mem_ready (1): memory handshake, present only under MEM_WAIT_EN.
REQ-005 SHALL have outputs pc_write, adr_src, mem_write, ir_write and reg_write, each 1 bit.
REQ-006 SHALL have outputs result_src [1:0], alu_src_a [1:0], alu_src_b [1:0], imm_src [1:0] and alu_control [2:0].
REQ-007 SHALL have output illegal (1): one-cycle pulse on an unsupported opcode.
REQ-008 SHALL have output state [3:0]: current state encoding, for debug.

Function
REQ-009 SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10.
REQ-010 SHALL transition: FETCH->DECODE; DECODE->MEMADR (lw 0000011, sw 0100011), EXECR (0110011), EXECI (0010011), JAL (1101111), BRANCH (1100011), any other opcode->FETCH with illegal=1.
REQ-011 SHALL transition: MEMADR->MEMREAD (op[5]=0) or MEMWRITE (op[5]=1); MEMREAD->MEMWB; EXECR/EXECI/JAL->ALUWB; MEMWB/MEMWRITE/ALUWB/BRANCH->FETCH.
REQ-012 FETCH outputs SHALL be: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ALU add, result_src=10, pc_update=1.
REQ-013 DECODE outputs SHALL be: alu_src_a=01, alu_src_b=01, ALU add (branch/jump target precompute).
REQ-014 MEMADR outputs SHALL be a_src=10, b_src=01, add; MEMREAD adr_src=1, result_src=00; MEMWB result_src=01, reg_write=1; MEMWRITE adr_src=1, mem_write=1.
REQ-015 EXECR outputs SHALL be a_src=10, b_src=00, ALU per funct; EXECI a_src=10, b_src=01, ALU per funct; ALUWB result_src=00, reg_write=1.
REQ-016 JAL outputs SHALL be a_src=01, b_src=10, add, result_src=00, pc_update=1; BRANCH outputs a_src=10, b_src=00, sub, result_src=00, branch=1.
REQ-017 pc_write SHALL equal pc_update | (branch & (zero ^ funct3[0])), giving beq/bne.
REQ-018 imm_src SHALL be combinational from op: I/lw=00, sw=01, branch=10, jal=11, other=00.
REQ-019 alu_control SHALL be 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
REQ-020 funct decode SHALL map funct3 000 to sub iff op[5]&funct7b5, else add; 001 sll; 010 slt; 100 xor; 101 srl; 110 or; 111 and; 011 add.
REQ-021 All outputs not listed for a state SHALL be 0; no X SHALL be driven in any state.
REQ-022 Latencies in cycles SHALL be: lw 5, sw 4, R/I 4, jal 4, branch 3, illegal 2.

Reset
REQ-023 Reset SHALL force state=FETCH immediately (asynchronous).
REQ-024 While reset is high, all write enables (pc_write, ir_write, reg_write, mem_write) SHALL be forced to 0 and illegal SHALL be 0.
REQ-025 Reset asserted mid-instruction SHALL abandon that instruction, with no partial write after reset.

Configuration
REQ-026 Macro MEM_WAIT_EN SHALL, when defined, add mem_ready and hold FETCH, MEMREAD and MEMWRITE until mem_ready=1.
REQ-027 Under MEM_WAIT_EN, ir_write and pc_write in FETCH SHALL assert only in the cycle mem_ready=1.
REQ-028 Under MEM_WAIT_EN, mem_write SHALL be held while waiting, and adr_src SHALL be held stable.
REQ-029 Without MEM_WAIT_EN, memory states SHALL be single-cycle and no mem_ready port SHALL exist.

Structure
REQ-030 Package mc_pkg SHALL hold the state enum, opcode constants and alu_control codes.
REQ-031 Sub-module alu_op_decode SHALL implement REQ-019/020 combinationally.

Verification
REQ-032 The bench SHALL check: reset mid-EXECR -> state=0 same cycle, reg_write=0; first cycle after release shows ir_write=1, pc_write=1.
REQ-033 The bench SHALL check: lw (op=0000011) -> states 0,1,2,3,4; reg_write=1 only in state 4 with result_src=01.
REQ-034 The bench SHALL check: sub (op=0110011, funct7b5=1, funct3=000) -> EXECR alu_control=001; with funct7b5=0 -> 000.
REQ-035 The bench SHALL check: beq with zero=1 -> pc_write=1 in BRANCH; bne (funct3=001) with zero=1 -> pc_write=0.
REQ-036 The bench SHALL check: op=1111111 -> illegal=1 one cycle in DECODE, next state FETCH, no writes.
REQ-037 The bench SHALL check: MEM_WAIT_EN, sw with mem_ready low 3 cycles -> MEMWRITE held 4 cycles with mem_write=1, then FETCH.
